// File: rtl/sn_fwd_buffer.sv
// sn_fwd_buffer
// Single-slot packet buffer between the AXI-Stream snooper and forwarder. One packet is
// written by the snooper, held until an external verdict arrives, then either served to
// the forwarder (accept) or discarded and counted (reject).
//
// Ports
//   clk, rst            sole clock; synchronous active-high reset
//   sn_addr/sn_wr_data  snooper word write (sn_wr_en strobe, sn_byte_inc valid bytes)
//   sn_done             pulse: packet fully written
//   rdy_for_sn          buffer free; rdy_for_sn_ack claims it
//   vrd_req             verdict wanted; vrd_valid/vrd_accept deliver it
//   fwd_addr/fwd_rd_en  forwarder word read, data on fwd_rd_data one cycle later with
//                       fwd_rd_data_vld
//   fwd_byte_len        stored packet length in bytes (meaningful while forwarding)
//   fwd_done            pulse: forwarding complete
//   rdy_for_fwd         accepted packet waiting; rdy_for_fwd_ack claims it
//   num_dropped         saturating count of rejected packets
module sn_fwd_buffer #(
   parameter int unsigned PACKET_MEM_BYTES  = 2048,
   parameter int unsigned SN_FWD_DATA_WIDTH = 64,
   parameter int unsigned PLEN_WIDTH        = 32,
   localparam int unsigned ADDR_W = $clog2(PACKET_MEM_BYTES) - $clog2(SN_FWD_DATA_WIDTH / 8),
   localparam int unsigned INC_W  = $clog2(SN_FWD_DATA_WIDTH / 8) + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   // Snooper
   input  logic [ADDR_W-1:0]            sn_addr,
   input  logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data,
   input  logic                         sn_wr_en,
   input  logic [INC_W-1:0]             sn_byte_inc,
   input  logic                         sn_done,
   output logic                         rdy_for_sn,
   input  logic                         rdy_for_sn_ack,
   // Verdict
   output logic                         vrd_req,
   input  logic                         vrd_valid,
   input  logic                         vrd_accept,
   // Forwarder
   input  logic [ADDR_W-1:0]            fwd_addr,
   input  logic                         fwd_rd_en,
   output logic [SN_FWD_DATA_WIDTH-1:0] fwd_rd_data,
   output logic                         fwd_rd_data_vld,
   output logic [PLEN_WIDTH-1:0]        fwd_byte_len,
   input  logic                         fwd_done,
   output logic                         rdy_for_fwd,
   input  logic                         rdy_for_fwd_ack,
   // Status
   output logic [15:0]                  num_dropped
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = $clog2(PACKET_MEM_BYTES) + 1;
   localparam logic [CNT_W:0] MAX_BYTES = {1'b0, CNT_W'(PACKET_MEM_BYTES)};

   typedef enum logic [2:0] {
      StIdle,
      StSnoop,
      StVerdict,
      StFwdRdy,
      StFwd
   } state_e;

   state_e                       state_q, state_d;
   logic [CNT_W-1:0]             bytes_q, bytes_d;
   logic [15:0]                  dropped_q, dropped_d;
   logic [SN_FWD_DATA_WIDTH-1:0] rd_data_q;
   logic                         rd_vld_q;
   logic                         mem_we;
   logic                         rd_fire;

   logic [SN_FWD_DATA_WIDTH-1:0] mem [DEPTH];

   // One extra bit so the sum cannot wrap before the saturation compare.
   logic [CNT_W:0] inc_ext;
   logic [CNT_W:0] bytes_sum;
   logic [CNT_W-1:0] bytes_sat;

   assign inc_ext   = {{(CNT_W + 1 - INC_W){1'b0}}, sn_byte_inc};
   assign bytes_sum = {1'b0, bytes_q} + inc_ext;
   assign bytes_sat = (bytes_sum > MAX_BYTES) ? MAX_BYTES[CNT_W-1:0] : bytes_sum[CNT_W-1:0];

   always_comb begin
      state_d   = state_q;
      bytes_d   = bytes_q;
      dropped_d = dropped_q;
      mem_we    = 1'b0;
      rd_fire   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rdy_for_sn_ack) begin
               bytes_d = '0;
               state_d = StSnoop;
            end
         end
         StSnoop: begin
            // A write coinciding with sn_done still lands and counts.
            if (sn_wr_en) begin
               mem_we  = 1'b1;
               bytes_d = bytes_sat;
            end
            if (sn_done) begin
               state_d = StVerdict;
            end
         end
         StVerdict: begin
            if (vrd_valid) begin
               if (vrd_accept) begin
                  state_d = StFwdRdy;
               end else begin
                  if (dropped_q != 16'hFFFF) begin
                     dropped_d = dropped_q + 16'd1;
                  end
                  state_d = StIdle;
               end
            end
         end
         StFwdRdy: begin
            if (rdy_for_fwd_ack) begin
               state_d = StFwd;
            end
         end
         StFwd: begin
            rd_fire = fwd_rd_en;
            if (fwd_done) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         bytes_q   <= '0;
         dropped_q <= '0;
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bytes_q   <= bytes_d;
         dropped_q <= dropped_d;
         rd_vld_q  <= rd_fire;
         // Data is held when no read fires so the last word stays visible.
         if (rd_fire) begin
            rd_data_q <= mem[fwd_addr];
         end
      end
   end

   // Packet memory is never cleared; only words written in the current packet matter.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[sn_addr] <= sn_wr_data;
      end
   end

   assign rdy_for_sn      = (state_q == StIdle);
   assign vrd_req         = (state_q == StVerdict);
   assign rdy_for_fwd     = (state_q == StFwdRdy);
   assign fwd_byte_len    = ((state_q == StFwdRdy) || (state_q == StFwd)) ?
                            PLEN_WIDTH'(bytes_q) : '0;
   assign fwd_rd_data     = rd_data_q;
   assign fwd_rd_data_vld = rd_vld_q;
   assign num_dropped     = dropped_q;

endmodule

// File: tb/tb_sn_fwd_buffer.sv
module tb_sn_fwd_buffer;

   localparam int unsigned MEM_BYTES = 2048;
   localparam int unsigned WORDS     = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  sn_addr;
   logic [63:0] sn_wr_data;
   logic        sn_wr_en;
   logic [3:0]  sn_byte_inc;
   logic        sn_done;
   logic        rdy_for_sn;
   logic        rdy_for_sn_ack;
   logic        vrd_req;
   logic        vrd_valid;
   logic        vrd_accept;
   logic [7:0]  fwd_addr;
   logic        fwd_rd_en;
   logic [63:0] fwd_rd_data;
   logic        fwd_rd_data_vld;
   logic [31:0] fwd_byte_len;
   logic        fwd_done;
   logic        rdy_for_fwd;
   logic        rdy_for_fwd_ack;
   logic [15:0] num_dropped;

   sn_fwd_buffer #(
      .PACKET_MEM_BYTES (MEM_BYTES),
      .SN_FWD_DATA_WIDTH(64),
      .PLEN_WIDTH       (32)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sn_addr         (sn_addr),
      .sn_wr_data      (sn_wr_data),
      .sn_wr_en        (sn_wr_en),
      .sn_byte_inc     (sn_byte_inc),
      .sn_done         (sn_done),
      .rdy_for_sn      (rdy_for_sn),
      .rdy_for_sn_ack  (rdy_for_sn_ack),
      .vrd_req         (vrd_req),
      .vrd_valid       (vrd_valid),
      .vrd_accept      (vrd_accept),
      .fwd_addr        (fwd_addr),
      .fwd_rd_en       (fwd_rd_en),
      .fwd_rd_data     (fwd_rd_data),
      .fwd_rd_data_vld (fwd_rd_data_vld),
      .fwd_byte_len    (fwd_byte_len),
      .fwd_done        (fwd_done),
      .rdy_for_fwd     (rdy_for_fwd),
      .rdy_for_fwd_ack (rdy_for_fwd_ack),
      .num_dropped     (num_dropped)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int unsigned cyc_cnt = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Reference model: words of the current packet, byte total, drop total.
   logic [63:0] ref_mem [WORDS];
   int          ref_bytes = 0;
   int          ref_drops = 0;

   typedef struct {
      logic [63:0] data;
      int unsigned due;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_cnt);
      end
   endtask

   // Monitor: every valid read beat must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (fwd_rd_data_vld) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_vld: got vld=1 data %0h expected no read", fwd_rd_data);
         end else begin
            mon_e = sb.pop_front();
            check("rd_data", fwd_rd_data, mon_e.data);
            check("rd_latency", 64'(cyc_cnt), 64'(mon_e.due));
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      sn_addr = '0; sn_wr_data = '0; sn_wr_en = 1'b0; sn_byte_inc = '0; sn_done = 1'b0;
      rdy_for_sn_ack = 1'b0; vrd_valid = 1'b0; vrd_accept = 1'b0; fwd_addr = '0;
      fwd_rd_en = 1'b0; fwd_done = 1'b0; rdy_for_fwd_ack = 1'b0;
   endtask

   task automatic check_reset_vals();
      check("rst_rdy_for_sn", rdy_for_sn, 1);
      check("rst_vrd_req", vrd_req, 0);
      check("rst_rdy_for_fwd", rdy_for_fwd, 0);
      check("rst_vld", fwd_rd_data_vld, 0);
      check("rst_rd_data", fwd_rd_data, 0);
      check("rst_byte_len", fwd_byte_len, 0);
      check("rst_num_dropped", num_dropped, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ref_drops = 0;
      check_reset_vals();
   endtask

   task automatic claim();
      check("rdy_for_sn_idle", rdy_for_sn, 1);
      rdy_for_sn_ack = 1'b1;
      tick();
      rdy_for_sn_ack = 1'b0;
      check("rdy_for_sn_after_ack", rdy_for_sn, 0);
      ref_bytes = 0;
   endtask

   task automatic write_word(input int addr, input logic [63:0] data, input int inc,
                             input bit done);
      sn_addr = 8'(addr); sn_wr_data = data; sn_byte_inc = 4'(inc);
      sn_wr_en = 1'b1; sn_done = done;
      tick();
      sn_wr_en = 1'b0; sn_done = 1'b0;
      ref_mem[addr] = data;
      ref_bytes = (ref_bytes + inc > MEM_BYTES) ? MEM_BYTES : ref_bytes + inc;
      if (done) check("vrd_req_after_done", vrd_req, 1);
   endtask

   task automatic finish_snoop();
      sn_done = 1'b1;
      tick();
      sn_done = 1'b0;
      check("vrd_req_after_done", vrd_req, 1);
   endtask

   task automatic give_verdict(input bit accept);
      vrd_valid = 1'b1; vrd_accept = accept;
      tick();
      vrd_valid = 1'b0; vrd_accept = 1'b0;
      check("vrd_req_after_verdict", vrd_req, 0);
      if (accept) begin
         check("rdy_for_fwd_after_accept", rdy_for_fwd, 1);
         check("byte_len_fwd_rdy", fwd_byte_len, 64'(ref_bytes));
      end else begin
         ref_drops = (ref_drops < 65535) ? ref_drops + 1 : 65535;
         check("rdy_for_fwd_after_reject", rdy_for_fwd, 0);
         check("rdy_for_sn_after_reject", rdy_for_sn, 1);
         check("num_dropped", num_dropped, 64'(ref_drops));
      end
   endtask

   task automatic fwd_claim();
      rdy_for_fwd_ack = 1'b1;
      tick();
      rdy_for_fwd_ack = 1'b0;
      check("rdy_for_fwd_after_ack", rdy_for_fwd, 0);
      check("byte_len_fwd", fwd_byte_len, 64'(ref_bytes));
   endtask

   task automatic read_word(input int addr, input bit last);
      fwd_addr = 8'(addr); fwd_rd_en = 1'b1; fwd_done = last;
      sb.push_back('{data: ref_mem[addr], due: cyc_cnt + 1});
      tick();
      fwd_rd_en = 1'b0; fwd_done = 1'b0;
      if (last) check("rdy_for_sn_after_fwd_done", rdy_for_sn, 1);
   endtask

   task automatic run_packet(input int nwords, input bit accept);
      claim();
      for (int i = 0; i < nwords; i++) begin
         write_word(i, {$urandom, $urandom}, $urandom_range(0, 8), 1'b0);
         if ($urandom_range(0, 1) == 1) tick();
      end
      finish_snoop();
      if ($urandom_range(0, 1) == 1) begin
         tick();
         check("vrd_req_hold", vrd_req, 1);
      end
      give_verdict(accept);
      if (accept) begin
         fwd_claim();
         for (int r = 0; r < nwords + 1; r++) begin
            read_word($urandom_range(0, nwords - 1), r == nwords);
            if (r != nwords && $urandom_range(0, 2) == 0) tick();
         end
      end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_reset_vals();

      // Directed accept path.
      claim();
      write_word(0, 64'h1111_1111_1111_1111, 8, 1'b0);
      write_word(1, 64'h2222_2222_2222_2222, 8, 1'b0);
      write_word(2, 64'h3333_3333_3333_3333, 5, 1'b0);
      finish_snoop();
      give_verdict(1'b1);
      check("byte_len_21", fwd_byte_len, 21);
      fwd_claim();
      read_word(0, 1'b0);
      read_word(1, 1'b0);
      read_word(2, 1'b1);

      // Reject path, three times.
      for (int k = 0; k < 3; k++) begin
         claim();
         write_word(0, 64'h1111_1111_1111_1111, 8, 1'b0);
         write_word(1, 64'h2222_2222_2222_2222, 8, 1'b0);
         write_word(2, 64'h3333_3333_3333_3333, 5, 1'b0);
         finish_snoop();
         give_verdict(1'b0);
      end
      check("num_dropped_3", num_dropped, 3);

      // Strobes in IDLE are ignored.
      sn_wr_en = 1'b1; sn_addr = 8'd0; sn_wr_data = 64'hDEAD; sn_byte_inc = 4'd8;
      sn_done = 1'b1; vrd_valid = 1'b1; rdy_for_fwd_ack = 1'b1; fwd_rd_en = 1'b1;
      fwd_done = 1'b1;
      tick();
      clear_inputs();
      check("idle_stays_rdy", rdy_for_sn, 1);
      check("idle_no_vrd_req", vrd_req, 0);
      check("idle_no_vld", fwd_rd_data_vld, 0);

      // Strobes in SNOOP, VERDICT and FWD_RDY that belong elsewhere are ignored.
      claim();
      fwd_rd_en = 1'b1; vrd_valid = 1'b1; vrd_accept = 1'b1; rdy_for_fwd_ack = 1'b1;
      fwd_done = 1'b1; rdy_for_sn_ack = 1'b1;
      tick();
      clear_inputs();
      check("snoop_no_vld", fwd_rd_data_vld, 0);
      check("snoop_no_vrd_req", vrd_req, 0);
      check("snoop_no_rdy_for_sn", rdy_for_sn, 0);
      check("snoop_no_rdy_for_fwd", rdy_for_fwd, 0);
      write_word(0, 64'hA0A0_0000_0000_00A0, 8, 1'b0);
      write_word(1, 64'hA1A1_0000_0000_00A1, 8, 1'b0);
      write_word(2, 64'hA2A2_0000_0000_00A2, 3, 1'b1);
      sn_wr_en = 1'b1; sn_addr = 8'd0; sn_wr_data = 64'hBAD0; sn_byte_inc = 4'd8;
      rdy_for_fwd_ack = 1'b1; fwd_rd_en = 1'b1;
      tick();
      clear_inputs();
      check("verdict_hold", vrd_req, 1);
      check("verdict_no_vld", fwd_rd_data_vld, 0);
      give_verdict(1'b1);
      check("byte_len_19", fwd_byte_len, 19);
      sn_wr_en = 1'b1; sn_addr = 8'd1; sn_wr_data = 64'hBAD1; sn_byte_inc = 4'd8;
      fwd_rd_en = 1'b1; vrd_valid = 1'b1; vrd_accept = 1'b0;
      tick();
      clear_inputs();
      check("fwd_rdy_hold", rdy_for_fwd, 1);
      check("fwd_rdy_no_drop", num_dropped, 64'(ref_drops));
      check("fwd_rdy_no_vld", fwd_rd_data_vld, 0);
      fwd_claim();
      read_word(0, 1'b0);
      read_word(1, 1'b0);
      read_word(2, 1'b1);

      // Byte counter saturation: 300 x 8 bytes wraps the addresses and clamps the length.
      claim();
      for (int i = 0; i < 300; i++) begin
         write_word(i % WORDS, {$urandom, $urandom}, 8, i == 299);
      end
      give_verdict(1'b1);
      check("byte_len_sat", fwd_byte_len, 2048);
      fwd_claim();
      read_word(43, 1'b0);
      read_word(0, 1'b0);
      read_word(255, 1'b1);

      // Randomised packets.
      for (int p = 0; p < 25; p++) begin
         run_packet($urandom_range(1, 12), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) tick();
      end

      // Reset while snooping, then a short packet.
      claim();
      write_word(0, 64'h5555, 8, 1'b0);
      write_word(1, 64'h6666, 8, 1'b0);
      do_reset();
      claim();
      write_word(0, 64'h7777_8888, 4, 1'b1);
      give_verdict(1'b1);
      check("byte_len_4", fwd_byte_len, 4);
      fwd_claim();
      read_word(0, 1'b1);

      // Reset while forwarding.
      claim();
      write_word(0, 64'h9999, 8, 1'b0);
      write_word(1, 64'hAAAA, 8, 1'b1);
      give_verdict(1'b1);
      fwd_claim();
      read_word(1, 1'b0);
      tick();
      do_reset();
      claim();
      write_word(0, 64'h1234, 4, 1'b1);
      give_verdict(1'b1);
      check("byte_len_4_after_fwd_rst", fwd_byte_len, 4);
      fwd_claim();
      read_word(0, 1'b1);

      // Drop counter saturation: preload near the top, then reject twice.
      force dut.dropped_q = 16'hFFFE;
      tick();
      release dut.dropped_q;
      ref_drops = 65534;
      tick();
      check("num_dropped_preload", num_dropped, 64'(ref_drops));
      for (int k = 0; k < 2; k++) begin
         claim();
         write_word(0, 64'h0F0F, 8, 1'b1);
         give_verdict(1'b0);
      end
      check("num_dropped_sat", num_dropped, 16'hFFFF);

      tick();
      tick();
      check("scoreboard_drained", 64'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
